button_ctrl: RTL and testbench

Front-end input stage for the four board push-buttons (BTNU, BTNR, BTND, BTNL). It synchronizes each raw button to the processor clock, debounces it, and detects press edges. Each press is encoded into a sticky 3-bit code, which the memory-mapped read path returns to the processor at data address 0. The code is held until the processor acknowledges it by reading, so a short press is never lost between polls.

---
 rtl/button_ctrl.sv | 105 ++++++++++
 tb/tb_button_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// Push-button front end: per-button synchronizer and debouncer, press-edge detection,
// and a sticky priority-encoded press code that is cleared by a processor read.
module button_ctrl #(
  parameter int DB_COUNT = 290000,
  parameter int CNT_W    = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       rd_ack,
  output logic [2:0] button_reg,
  output logic [3:0] btn_level,
  output logic       press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit order everywhere is {L, D, R, U}; index 0 is the highest-priority button.
  logic [3:0]       raw_s;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       db_q;
  logic [3:0]       db_d;
  logic [3:0]       db_dly_q;
  logic [3:0]       rise_s;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [2:0]       button_reg_q;
  logic [2:0]       button_reg_d;
  logic             press_pulse_q;
  logic             press_pulse_d;

  assign raw_s  = {BTNL, BTND, BTNR, BTNU};
  assign rise_s = db_q & ~db_dly_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // A new press always beats a same-cycle read acknowledge.
  always_comb begin
    button_reg_d  = button_reg_q;
    press_pulse_d = 1'b0;
    if (rise_s != 4'b0000) begin
      press_pulse_d = 1'b1;
      if (rise_s[0]) begin
        button_reg_d = 3'd1;
      end else if (rise_s[1]) begin
        button_reg_d = 3'd2;
      end else if (rise_s[2]) begin
        button_reg_d = 3'd3;
      end else begin
        button_reg_d = 3'd4;
      end
    end else if (rd_ack) begin
      button_reg_d = 3'd0;
    end else begin
      button_reg_d = button_reg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 4'b0000;
      sync2_q       <= 4'b0000;
      db_q          <= 4'b0000;
      db_dly_q      <= 4'b0000;
      button_reg_q  <= 3'd0;
      press_pulse_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= raw_s;
      sync2_q       <= sync1_q;
      db_q          <= db_d;
      db_dly_q      <= db_q;
      button_reg_q  <= button_reg_d;
      press_pulse_q <= press_pulse_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign button_reg  = button_reg_q;
  assign btn_level   = db_q;
  assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random button/read traffic,
// compared every cycle against a sliding-window reference model.
module tb_button_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       BTNU = 1'b0;
  logic       BTNR = 1'b0;
  logic       BTND = 1'b0;
  logic       BTNL = 1'b0;
  logic       rd_ack = 1'b0;
  logic [2:0] button_reg;
  logic [3:0] btn_level;
  logic       press_pulse;

  int n_vec = 0;
  int n_err = 0;

  button_ctrl #(.DB_COUNT(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .BTNU(BTNU), .BTNR(BTNR), .BTND(BTND), .BTNL(BTNL),
    .rd_ack(rd_ack), .button_reg(button_reg), .btn_level(btn_level), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DB synchronized samples all disagree with it.
  logic [3:0] m_p1, m_p2, m_db, m_pend;
  logic [3:0] m_hist [DB];
  logic [2:0] m_reg;
  logic       m_pulse;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_p1 = 4'b0000; m_p2 = 4'b0000; m_db = 4'b0000; m_pend = 4'b0000;
    for (int j = 0; j < DB; j++) m_hist[j] = 4'b0000;
    m_reg = 3'd0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] raw, input logic ack);
    logic [3:0] s_now, new_db;
    logic all_diff;
    s_now = m_p2;
    m_p2  = m_p1;
    m_p1  = raw;
    for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = s_now;
    new_db = m_db;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) if (m_hist[j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) new_db[b] = ~m_db[b];
    end
    if (m_pend != 4'b0000) begin
      m_pulse = 1'b1;
      for (int b = 3; b >= 0; b--) if (m_pend[b]) m_reg = 3'(b + 1);
    end else begin
      m_pulse = 1'b0;
      if (ack) m_reg = 3'd0;
    end
    m_pend = new_db & ~m_db;
    m_db   = new_db;
  endtask

  // raw is {L, D, R, U}; inputs change on the falling edge, outputs are checked 1 time unit after the rising edge.
  task automatic tick(input logic [3:0] raw, input logic ack, input logic rst);
    @(negedge clk);
    {BTNL, BTND, BTNR, BTNU} = raw;
    rd_ack = ack;
    reset  = rst;
    @(posedge clk);
    if (rst) model_clear();
    else model_step(raw, ack);
    #1;
    check_eq("button_reg", 32'(button_reg), 32'(m_reg));
    check_eq("btn_level", 32'(btn_level), 32'(m_db));
    check_eq("press_pulse", 32'(press_pulse), 32'(m_pulse));
  endtask

  initial begin
    logic [3:0] raw;
    logic [3:0] bounce [13];
    logic ack, rst;
    model_clear();

    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
    check_eq("reset_reg", 32'(button_reg), 32'd0);
    check_eq("reset_lvl", 32'(btn_level), 32'd0);

    for (int i = 1; i <= 7; i++) begin
      tick(4'b0010, 1'b0, 1'b0);
      if (i == 6) check_eq("clean_early", 32'(button_reg), 32'd0);
    end
    check_eq("clean_reg", 32'(button_reg), 32'd2);
    check_eq("clean_pulse", 32'(press_pulse), 32'd1);
    check_eq("clean_lvl", 32'(btn_level), 32'b0010);
    tick(4'b0010, 1'b0, 1'b0);
    check_eq("clean_pulse_off", 32'(press_pulse), 32'd0);
    check_eq("clean_hold", 32'(button_reg), 32'd2);

    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    bounce = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 13; i++) tick(bounce[i], 1'b0, 1'b0);
    check_eq("bounce_lvl", 32'(btn_level), 32'd0);
    check_eq("bounce_reg", 32'(button_reg), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0001, 1'b0, 1'b0);
      if (i == 7) check_eq("bounce_press", 32'(button_reg), 32'd1);
    end

    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(4'b0100, 1'b0, 1'b0);
    check_eq("read_pre", 32'(button_reg), 32'd3);
    tick(4'b0100, 1'b1, 1'b0);
    check_eq("read_clear", 32'(button_reg), 32'd0);
    for (int i = 1; i <= 7; i++) tick(4'b1100, (i == 7), 1'b0);
    check_eq("collision", 32'(button_reg), 32'd4);

    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(4'b1100, 1'b0, 1'b0);
    check_eq("simul_reg", 32'(button_reg), 32'd3);
    check_eq("simul_pulse", 32'(press_pulse), 32'd1);
    tick(4'b1100, 1'b0, 1'b0);
    check_eq("simul_single", 32'(press_pulse), 32'd0);
    for (int i = 0; i < 7; i++) tick(4'b1101, 1'b0, 1'b0);
    check_eq("overwrite", 32'(button_reg), 32'd1);

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reg", 32'(button_reg), 32'd0);
    check_eq("async_lvl", 32'(btn_level), 32'd0);
    check_eq("async_pulse", 32'(press_pulse), 32'd0);
    model_clear();
    tick(4'b1101, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) tick(4'b1000, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick(4'b1000, 1'b0, 1'b0);
      if (i == 6) check_eq("middb_early", 32'(button_reg), 32'd0);
    end
    check_eq("middb_press", 32'(button_reg), 32'd4);

    raw = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      ack = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(raw, ack, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
